store_queue: RTL and testbench

In-order store queue that sits directly downstream of the commit reorder buffer. It allocates one entry per store at rename/dispatch, in the same cycle as the ROB tag grant. It captures address and data from the store AGU, and marks entries committed from the ROB `commit_store_ids`/`commit_store_vals` ports. Committed stores drain one per cycle to the data-memory write port over a valid/ready handshake. On a pipeline flush it discards every uncommitted store and keeps every committed one.

---
 rtl/store_queue.sv | 199 +++++++++++++++++++
 tb/tb_store_queue.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue.sv
// In-order store queue between the ROB and the data-memory write port.
// Allocates at dispatch, fills from the AGU, drains committed stores.
module store_queue #(
  parameter int SQ_ENTRIES    = 8,
  parameter int ROB_ENTRIES   = 16,
  parameter int PIPE_WIDTH    = 2,
  parameter int CPU_ADDR_BITS = 32,
  parameter int N             = SQ_ENTRIES,
  parameter int TAG_W         = $clog2(ROB_ENTRIES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [PIPE_WIDTH-1:0]           sq_alloc_req,
  input  logic [PIPE_WIDTH*TAG_W-1:0]     sq_alloc_rob_tag,
  output logic [PIPE_WIDTH-1:0]           sq_alloc_gnt,
  output logic [PIPE_WIDTH*$clog2(N)-1:0] sq_alloc_idx,
  input  logic                            agu_valid,
  input  logic [$clog2(N)-1:0]            agu_sq_idx,
  input  logic [CPU_ADDR_BITS-1:0]        agu_addr,
  input  logic [31:0]                     agu_data,
  input  logic [1:0]                      agu_size,
  input  logic [PIPE_WIDTH*TAG_W-1:0]     commit_store_ids,
  input  logic [PIPE_WIDTH-1:0]           commit_store_vals,
  output logic                            mem_req_valid,
  output logic [CPU_ADDR_BITS-1:0]        mem_req_addr,
  output logic [31:0]                     mem_req_data,
  output logic [3:0]                      mem_req_be,
  input  logic                            mem_req_ready,
  output logic                            sq_empty,
  output logic                            sq_full
);

  localparam int IW = $clog2(N);
  localparam int PW = IW + 1;
  localparam int AW = CPU_ADDR_BITS - 2;

  logic [N-1:0]       valid_q;
  logic [N-1:0]       cmtd_q;
  logic [N-1:0]       aval_q;
  logic [TAG_W-1:0]   tag_q  [N];
  logic [AW-1:0]      addr_q [N];
  logic [31:0]        data_q [N];
  logic [3:0]         be_q   [N];

  logic [PW-1:0]      head_q;
  logic [PW-1:0]      cmt_q;
  logic [PW-1:0]      tail_q;

  logic [PW-1:0]      count;
  logic [PW-1:0]      free_cnt;
  logic [PW-1:0]      req_cnt;
  logic [PW-1:0]      gnt_cnt;
  logic [PW-1:0]      cmt_cnt;
  logic               can_alloc;
  logic [IW-1:0]      head_idx;
  logic [IW-1:0]      tail_idx;
  logic [IW-1:0]      alloc_slot [PIPE_WIDTH];
  logic [IW-1:0]      cmt_slot   [PIPE_WIDTH];
  logic [N-1:0]       cmt_set;
  logic [3:0]         agu_be;
  logic [31:0]        agu_wdata;
  logic               agu_hit;
  logic               drain;

  function automatic logic [PW-1:0] popc(
    input logic [PIPE_WIDTH-1:0] v,
    input int                    upto
  );
    popc = '0;
    for (int i = 0; i < PIPE_WIDTH; i++)
      if (i < upto && v[i])
        popc = popc + PW'(1);
  endfunction

  assign head_idx = head_q[IW-1:0];
  assign tail_idx = tail_q[IW-1:0];
  assign count    = tail_q - head_q;
  assign sq_empty = (count == '0);
  assign sq_full  = (count == PW'(N));

  // All-or-nothing grant; slots pack densely from tail
  always_comb begin
    req_cnt      = popc(sq_alloc_req, PIPE_WIDTH);
    free_cnt     = PW'(N) - count;
    can_alloc    = rst && !flush && (free_cnt >= req_cnt);
    sq_alloc_gnt = can_alloc ? sq_alloc_req : '0;
    gnt_cnt      = can_alloc ? req_cnt : '0;
    sq_alloc_idx = '0;
    for (int k = 0; k < PIPE_WIDTH; k++) begin
      alloc_slot[k] = tail_idx + IW'(popc(sq_alloc_req, k));
      if (sq_alloc_gnt[k])
        sq_alloc_idx[k*IW +: IW] = alloc_slot[k];
    end
  end

  // In-order commit marks consecutive entries from cmt
  always_comb begin
    cmt_cnt = popc(commit_store_vals, PIPE_WIDTH);
    cmt_set = '0;
    for (int k = 0; k < PIPE_WIDTH; k++) begin
      cmt_slot[k] = cmt_q[IW-1:0] + IW'(popc(commit_store_vals, k));
      if (commit_store_vals[k])
        cmt_set[cmt_slot[k]] = 1'b1;
    end
  end

  // Lane replication and byte enables from size and low address
  always_comb begin
    agu_be    = 4'hF;
    agu_wdata = agu_data;
    unique case (1'b1)
      agu_size == 2'b00: begin
        agu_be    = 4'b0001 << agu_addr[1:0];
        agu_wdata = {4{agu_data[7:0]}};
      end
      agu_size == 2'b01: begin
        agu_be    = 4'b0011 << {agu_addr[1], 1'b0};
        agu_wdata = {2{agu_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign agu_hit       = agu_valid && valid_q[agu_sq_idx];
  assign mem_req_valid = valid_q[head_idx] & cmtd_q[head_idx]
                       & aval_q[head_idx];
  assign mem_req_addr  = mem_req_valid ? {addr_q[head_idx], 2'b00} : '0;
  assign mem_req_data  = mem_req_valid ? data_q[head_idx] : '0;
  assign mem_req_be    = mem_req_valid ? be_q[head_idx] : '0;
  assign drain         = mem_req_valid & mem_req_ready;

  // Pointer update; flush truncates tail back to post-commit cmt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_q + PW'(drain);
      cmt_q  <= cmt_q + cmt_cnt;
      tail_q <= flush ? (cmt_q + cmt_cnt) : (tail_q + gnt_cnt);
    end
  end

  // Entry state flags; flush drops only still-uncommitted entries
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      cmtd_q  <= '0;
      aval_q  <= '0;
    end else begin
      if (agu_hit)
        aval_q[agu_sq_idx] <= 1'b1;
      cmtd_q <= cmtd_q | cmt_set;
      if (drain) begin
        valid_q[head_idx] <= 1'b0;
        cmtd_q[head_idx]  <= 1'b0;
        aval_q[head_idx]  <= 1'b0;
      end
      for (int k = 0; k < PIPE_WIDTH; k++) begin
        if (sq_alloc_gnt[k]) begin
          valid_q[alloc_slot[k]] <= 1'b1;
          cmtd_q[alloc_slot[k]]  <= 1'b0;
          aval_q[alloc_slot[k]]  <= 1'b0;
        end
      end
      if (flush) begin
        for (int i = 0; i < N; i++)
          if (!(cmtd_q[i] || cmt_set[i]))
            valid_q[i] <= 1'b0;
      end
    end
  end

  // Payload storage; read only while the entry is valid
  always_ff @(posedge clk) begin
    if (agu_hit) begin
      addr_q[agu_sq_idx] <= agu_addr[CPU_ADDR_BITS-1:2];
      data_q[agu_sq_idx] <= agu_wdata;
      be_q[agu_sq_idx]   <= agu_be;
    end
    for (int k = 0; k < PIPE_WIDTH; k++)
      if (sq_alloc_gnt[k])
        tag_q[alloc_slot[k]] <= sq_alloc_rob_tag[k*TAG_W +: TAG_W];
  end

  // Commit order must match allocation order
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_WIDTH; k++)
        if (commit_store_vals[k])
          assert (tag_q[cmt_slot[k]] ==
                  commit_store_ids[k*TAG_W +: TAG_W])
            else $error("store_queue commit tag out of order");
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue.
// Scoreboard of expected memory writes plus directed corner cases.
module tb_store_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  sq_alloc_req = '0;
  logic [7:0]  sq_alloc_rob_tag = '0;
  logic [1:0]  sq_alloc_gnt;
  logic [5:0]  sq_alloc_idx;
  logic        agu_valid = 1'b0;
  logic [2:0]  agu_sq_idx = '0;
  logic [31:0] agu_addr = '0;
  logic [31:0] agu_data = '0;
  logic [1:0]  agu_size = '0;
  logic [7:0]  commit_store_ids = '0;
  logic [1:0]  commit_store_vals = '0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_be;
  logic        mem_req_ready = 1'b0;
  logic        sq_empty;
  logic        sq_full;

  store_queue #(
    .SQ_ENTRIES(8),
    .ROB_ENTRIES(16),
    .PIPE_WIDTH(2),
    .CPU_ADDR_BITS(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .sq_alloc_req(sq_alloc_req),
    .sq_alloc_rob_tag(sq_alloc_rob_tag),
    .sq_alloc_gnt(sq_alloc_gnt),
    .sq_alloc_idx(sq_alloc_idx),
    .agu_valid(agu_valid),
    .agu_sq_idx(agu_sq_idx),
    .agu_addr(agu_addr),
    .agu_data(agu_data),
    .agu_size(agu_size),
    .commit_store_ids(commit_store_ids),
    .commit_store_vals(commit_store_vals),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data),
    .mem_req_be(mem_req_be),
    .mem_req_ready(mem_req_ready),
    .sq_empty(sq_empty),
    .sq_full(sq_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
  } vec_t;

  req_t sb[$];
  int   acc_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   cyc = 0;
  int   tail_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pop the scoreboard on every accepted memory write
  always @(negedge clk) begin
    if (rst && mem_req_valid && mem_req_ready) begin
      req_t e;
      acc_cnt++;
      acc_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req actual=%0h required=none",
                 mem_req_addr);
      end else begin
        e = sb.pop_front();
        chk("req_addr", mem_req_addr, e.addr);
        chk("req_data", mem_req_data, e.data);
        chk("req_be", mem_req_be, e.be);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    req_t e;
    e.addr = a;
    e.data = d;
    e.be   = be;
    sb.push_back(e);
  endtask

  task automatic alloc1(input logic [3:0] tag, output logic [2:0] idx);
    idx = 3'(tail_m % 8);
    sq_alloc_req     = 2'b01;
    sq_alloc_rob_tag = {4'd0, tag};
    @(negedge clk);
    chk("alloc_gnt", sq_alloc_gnt, 2'b01);
    chk("alloc_idx", sq_alloc_idx, {3'd0, idx});
    tick();
    sq_alloc_req = '0;
    tail_m++;
  endtask

  task automatic agu(input logic [2:0] idx, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] sz);
    agu_valid  = 1'b1;
    agu_sq_idx = idx;
    agu_addr   = a;
    agu_data   = d;
    agu_size   = sz;
    tick();
    agu_valid = 1'b0;
  endtask

  task automatic commit(input logic [7:0] ids, input logic [1:0] vals);
    commit_store_ids  = ids;
    commit_store_vals = vals;
    tick();
    commit_store_vals = '0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && sq_empty) break;
    end
    chk("drain_done", 64'(sb.size()), 0);
    chk("drain_empty", sq_empty, 1'b1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [7];
    logic [2:0]  ix;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [3:0]  b0;
    int          n0;

    vt[0] = '{2'b00, 32'h8000, 32'hCAFE00F1, 32'h8000, 32'hF1F1F1F1, 4'b0001};
    vt[1] = '{2'b00, 32'h8001, 32'hCAFE00F2, 32'h8000, 32'hF2F2F2F2, 4'b0010};
    vt[2] = '{2'b00, 32'h8002, 32'hCAFE00F3, 32'h8000, 32'hF3F3F3F3, 4'b0100};
    vt[3] = '{2'b00, 32'h8003, 32'hCAFE00F4, 32'h8000, 32'hF4F4F4F4, 4'b1000};
    vt[4] = '{2'b01, 32'h8100, 32'h9876BEEF, 32'h8100, 32'hBEEFBEEF, 4'b0011};
    vt[5] = '{2'b01, 32'h8102, 32'h98761234, 32'h8100, 32'h12341234, 4'b1100};
    vt[6] = '{2'b10, 32'h8203, 32'h0BADF00D, 32'h8200, 32'h0BADF00D, 4'b1111};

    // reset values
    @(negedge clk);
    chk("rst_empty", sq_empty, 1'b1);
    chk("rst_full", sq_full, 1'b0);
    chk("rst_valid", mem_req_valid, 1'b0);
    chk("rst_be", mem_req_be, 4'd0);
    chk("rst_gnt", sq_alloc_gnt, 2'b00);
    tick();
    rst = 1'b1;
    tick();

    // two stores, half then word, committed together
    sq_alloc_req     = 2'b11;
    sq_alloc_rob_tag = {4'd4, 4'd3};
    @(negedge clk);
    chk("pair_gnt", sq_alloc_gnt, 2'b11);
    chk("pair_idx", sq_alloc_idx, 6'b001_000);
    tick();
    sq_alloc_req = '0;
    tail_m = 2;
    agu(3'd0, 32'h1002, 32'h0000ABCD, 2'b01);
    agu(3'd1, 32'h2000, 32'h11223344, 2'b10);
    @(negedge clk);
    chk("valid_before_commit", mem_req_valid, 1'b0);
    tick();
    mem_req_ready = 1'b1;
    push(32'h1000, 32'hABCDABCD, 4'b1100);
    push(32'h2000, 32'h11223344, 4'b1111);
    n0 = acc_cnt;
    commit({4'd4, 4'd3}, 2'b11);
    @(negedge clk);
    chk("valid_after_commit", mem_req_valid, 1'b1);
    wait_drain(20);
    chk("pair_accepts", 64'(acc_cnt - n0), 2);
    if (acc_cyc.size() >= 2)
      chk("back_to_back",
          64'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]), 1);

    // commit arrives before the address
    alloc1(4'd5, ix);
    commit({4'd0, 4'd5}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_req_without_addr", mem_req_valid, 1'b0);
      tick();
    end
    push(32'h3000, 32'h5A5A5A5A, 4'b0010);
    agu(ix, 32'h3001, 32'h1234565A, 2'b00);
    @(negedge clk);
    chk("req_after_late_addr", mem_req_valid, 1'b1);
    wait_drain(20);

    // backpressure holds the request stable
    mem_req_ready = 1'b0;
    alloc1(4'd6, ix);
    agu(ix, 32'h4000, 32'hDEADBEEF, 2'b10);
    commit({4'd0, 4'd6}, 2'b01);
    @(negedge clk);
    chk("bp_valid", mem_req_valid, 1'b1);
    a0 = mem_req_addr;
    d0 = mem_req_data;
    b0 = mem_req_be;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", mem_req_valid, 1'b1);
      chk("bp_hold_addr", mem_req_addr, a0);
      chk("bp_hold_data", mem_req_data, d0);
      chk("bp_hold_be", mem_req_be, b0);
    end
    chk("bp_addr", a0, 32'h4000);
    tick();
    push(32'h4000, 32'hDEADBEEF, 4'b1111);
    n0 = acc_cnt;
    mem_req_ready = 1'b1;
    tick();
    chk("bp_accept_one", 64'(acc_cnt - n0), 1);
    chk("bp_empty_after", sq_empty, 1'b1);

    // size/lane table, walking the index through wrap-around
    for (int i = 0; i < 7; i++) begin
      alloc1(4'(7 + i), ix);
      agu(ix, vt[i].addr, vt[i].data, vt[i].size);
      push(vt[i].exp_addr, vt[i].exp_data, vt[i].exp_be);
      commit({4'd0, 4'(7 + i)}, 2'b01);
      wait_drain(20);
    end

    // asynchronous reset in the middle of a pending drain
    mem_req_ready = 1'b0;
    alloc1(4'd14, ix);
    agu(ix, 32'h9000, 32'h1, 2'b10);
    commit({4'd0, 4'd14}, 2'b01);
    @(negedge clk);
    chk("pre_rst_valid", mem_req_valid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", mem_req_valid, 1'b0);
    chk("arst_addr", mem_req_addr, 32'd0);
    chk("arst_data", mem_req_data, 32'd0);
    chk("arst_be", mem_req_be, 4'd0);
    chk("arst_empty", sq_empty, 1'b1);
    chk("arst_full", sq_full, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tail_m = 0;

    // fill to full, then free one slot and wrap
    for (int j = 0; j < 4; j++) begin
      sq_alloc_req     = 2'b11;
      sq_alloc_rob_tag = {4'(2*j + 1), 4'(2*j)};
      @(negedge clk);
      chk("fill_gnt", sq_alloc_gnt, 2'b11);
      chk("fill_idx", sq_alloc_idx, {3'(2*j + 1), 3'(2*j)});
      tick();
    end
    sq_alloc_req = '0;
    @(negedge clk);
    chk("full_flag", sq_full, 1'b1);
    chk("full_not_empty", sq_empty, 1'b0);
    tick();
    sq_alloc_req = 2'b11;
    @(negedge clk);
    chk("full_no_grant", sq_alloc_gnt, 2'b00);
    tick();
    sq_alloc_req      = '0;
    agu_valid         = 1'b1;
    agu_sq_idx        = 3'd0;
    agu_addr          = 32'h6000;
    agu_data          = 32'h66666666;
    agu_size          = 2'b10;
    commit_store_ids  = 8'd0;
    commit_store_vals = 2'b01;
    push(32'h6000, 32'h66666666, 4'b1111);
    tick();
    agu_valid         = 1'b0;
    commit_store_vals = '0;
    mem_req_ready     = 1'b1;
    sq_alloc_req      = 2'b01;
    sq_alloc_rob_tag  = {4'd0, 4'd8};
    n0 = acc_cnt;
    @(negedge clk);
    chk("wrap_drain_valid", mem_req_valid, 1'b1);
    chk("no_grant_same_drain", sq_alloc_gnt, 2'b00);
    tick();
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk("wrap_gnt", sq_alloc_gnt, 2'b01);
    chk("wrap_idx", sq_alloc_idx, 6'd0);
    tick();
    sq_alloc_req = '0;
    @(negedge clk);
    chk("refull", sq_full, 1'b1);
    chk("wrap_accepts", 64'(acc_cnt - n0), 1);
    tick();

    // flush keeps committed entries, including a same-cycle commit
    for (int k = 1; k <= 3; k++) begin
      agu(3'(k), 32'h7000 + 32'(4*(k - 1)), 32'h70 + 32'(k), 2'b10);
      push(32'h7000 + 32'(4*(k - 1)), 32'h70 + 32'(k), 4'b1111);
    end
    commit({4'd2, 4'd1}, 2'b11);
    flush             = 1'b1;
    commit_store_ids  = {4'd0, 4'd3};
    commit_store_vals = 2'b01;
    sq_alloc_req      = 2'b01;
    sq_alloc_rob_tag  = {4'd0, 4'd9};
    @(negedge clk);
    chk("flush_no_grant", sq_alloc_gnt, 2'b00);
    tick();
    flush             = 1'b0;
    commit_store_vals = '0;
    sq_alloc_req      = '0;
    @(negedge clk);
    chk("flush_not_full", sq_full, 1'b0);
    chk("flush_not_empty", sq_empty, 1'b0);
    tick();
    n0 = acc_cnt;
    mem_req_ready = 1'b1;
    wait_drain(30);
    repeat (4) tick();
    chk("flush_accepts", 64'(acc_cnt - n0), 3);
    chk("flush_empty", sq_empty, 1'b1);
    tail_m = 4;
    alloc1(4'd10, ix);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
